// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
package regfile_pkg;

  localparam int unsigned RF_XLEN  = 32;
  localparam int unsigned RF_DEPTH = 32;

  typedef enum logic {
    RF_CLEAR,
    RF_IDLE
  } rf_state_e;

  // Index width for a given depth; never narrower than one bit.
  function automatic int unsigned rf_aw(input int unsigned depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits with read-port mux; a reservation beats a
// same-cycle write to the same index, and a full clear beats both.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH    = RF_DEPTH,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned AW       = rf_aw(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_all_i,
  input  logic                 wr_en_i,
  input  logic [AW-1:0]        wr_sel_i,
  input  logic                 rsv_en_i,
  input  logic [AW-1:0]        rsv_sel_i,
  input  logic [NUM_RD*AW-1:0] rd_sel_i,
  output logic [NUM_RD-1:0]    rd_pend_o
);

  logic [DEPTH-1:0] pend_q, pend_d;

  always_comb begin
    pend_d = pend_q;
    if (clr_all_i) begin
      pend_d = '0;
    end else begin
      if (wr_en_i)  pend_d[wr_sel_i]  = 1'b0;
      if (rsv_en_i) pend_d[rsv_sel_i] = 1'b1;
    end
    if (ZERO_REG != 0) pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  always_comb begin
    rd_pend_o = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      rd_pend_o[k] = pend_q[rd_sel_i[k*AW +: AW]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with optional zero register,
// write bypass, pending scoreboard and a sequential clear engine.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = RF_XLEN,
  parameter int unsigned DEPTH    = RF_DEPTH,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1,
  localparam int unsigned AW      = rf_aw(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_RD*AW-1:0]   rd_sel,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_pend,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_sel,
  input  logic [XLEN-1:0]        wr_data,
  input  logic                   rsv_en,
  input  logic [AW-1:0]          rsv_sel,
  input  logic                   clr_req,
  output logic                   clr_busy
);

  rf_state_e       state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic [XLEN-1:0] regs_q [DEPTH];
  logic            wr_ok, rsv_ok, clr_all;
  logic [NUM_RD-1:0] sb_pend;

  assign clr_busy = (state_q == RF_CLEAR);
  assign wr_ok    = wr_en && !clr_busy && !((ZERO_REG != 0) && (wr_sel == '0));
  assign rsv_ok   = rsv_en && !clr_busy;
  assign clr_all  = (state_q == RF_IDLE) && clr_req;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    unique case (state_q)
      RF_CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == AW'(DEPTH - 1)) begin
          state_d   = RF_IDLE;
          clr_idx_d = '0;
        end
      end
      RF_IDLE: begin
        if (clr_req) begin
          state_d   = RF_CLEAR;
          clr_idx_d = '0;
        end
      end
      default: begin
        state_d   = RF_CLEAR;
        clr_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RF_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Array has no reset of its own; the clear engine owns zeroing it.
  always_ff @(posedge clk) begin
    if (clr_busy)   regs_q[clr_idx_q] <= '0;
    else if (wr_ok) regs_q[wr_sel]    <= wr_data;
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin : g_rd
      logic [AW-1:0]   sel;
      logic [XLEN-1:0] val;
      sel = rd_sel[k*AW +: AW];
      val = regs_q[sel];
      if ((ZERO_REG != 0) && (sel == '0))        val = '0;
      if ((BYPASS != 0) && wr_ok && wr_sel == sel) val = wr_data;
      if (clr_busy)                              val = '0;
      rd_data[k*XLEN +: XLEN] = val;
    end
  end

  rf_scoreboard #(
    .DEPTH   (DEPTH),
    .NUM_RD  (NUM_RD),
    .ZERO_REG(ZERO_REG),
    .AW      (AW)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_all_i(clr_all),
    .wr_en_i  (wr_ok),
    .wr_sel_i (wr_sel),
    .rsv_en_i (rsv_ok),
    .rsv_sel_i(rsv_sel),
    .rd_sel_i (rd_sel),
    .rd_pend_o(sb_pend)
  );

  assign rd_pend = clr_busy ? '0 : sb_pend;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed table, random traffic against
// an array model, and clear/reset corner sequences.
module tb_regfile_mp;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NR    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic [NR*AW-1:0]     rd_sel;
  logic [NR*XLEN-1:0]   rd_data;
  logic [NR-1:0]        rd_pend;
  logic                 wr_en;
  logic [AW-1:0]        wr_sel;
  logic [XLEN-1:0]      wr_data;
  logic                 rsv_en;
  logic [AW-1:0]        rsv_sel;
  logic                 clr_req;
  logic                 clr_busy;
  logic [XLEN-1:0]      nb_data;
  logic                 nb_pend;
  logic                 nb_busy;

  regfile_mp #(
    .XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rd_sel(rd_sel), .rd_data(rd_data), .rd_pend(rd_pend),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data), .rsv_en(rsv_en),
    .rsv_sel(rsv_sel), .clr_req(clr_req), .clr_busy(clr_busy)
  );

  regfile_mp #(
    .XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(1), .ZERO_REG(1), .BYPASS(0)
  ) dut_nb (
    .clk(clk), .rst_n(rst_n), .rd_sel(rd_sel[AW-1:0]), .rd_data(nb_data), .rd_pend(nb_pend),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data), .rsv_en(rsv_en),
    .rsv_sel(rsv_sel), .clr_req(clr_req), .clr_busy(nb_busy)
  );

  // Reference model: register contents, pending set, and cycles of clear left.
  logic [XLEN-1:0] m_regs [DEPTH];
  bit              m_pend [DEPTH];
  int              m_left;
  int              checks   = 0;
  int              failures = 0;

  typedef struct {
    logic            we;
    logic [AW-1:0]   ws;
    logic [XLEN-1:0] wd;
    logic            re;
    logic [AW-1:0]   rs;
    logic [AW-1:0]   sel;
    logic [XLEN-1:0] ed;
    logic            ep;
    logic [XLEN-1:0] enb;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_left = DEPTH;
    for (int i = 0; i < DEPTH; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
  endfunction

  function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] sel, input bit bypass);
    if (m_left > 0) return '0;
    if (sel == 0) return '0;
    if (bypass && wr_en && wr_sel == sel) return wr_data;
    return m_regs[sel];
  endfunction

  function automatic logic exp_pend(input logic [AW-1:0] sel);
    if (m_left > 0) return 1'b0;
    return m_pend[sel];
  endfunction

  task automatic model_check();
    for (int k = 0; k < NR; k++) begin
      logic [AW-1:0] s;
      s = rd_sel[k*AW +: AW];
      chk($sformatf("rd_data%0d", k), rd_data[k*XLEN +: XLEN], exp_data(s, 1'b1));
      chk($sformatf("rd_pend%0d", k), 32'(rd_pend[k]), 32'(exp_pend(s)));
    end
    chk("clr_busy", 32'(clr_busy), 32'(m_left > 0));
    chk("nb_busy", 32'(nb_busy), 32'(m_left > 0));
    chk("nb_data", nb_data, exp_data(rd_sel[AW-1:0], 1'b0));
    chk("nb_pend", 32'(nb_pend), 32'(exp_pend(rd_sel[AW-1:0])));
  endtask

  task automatic model_update();
    if (!rst_n) begin
      model_reset();
    end else if (m_left > 0) begin
      m_left--;
    end else if (clr_req) begin
      model_reset();
    end else begin
      if (wr_en && wr_sel != 0) begin
        m_regs[wr_sel] = wr_data;
        m_pend[wr_sel] = 1'b0;
      end
      if (rsv_en && rsv_sel != 0) m_pend[rsv_sel] = 1'b1;
    end
  endtask

  task automatic idle();
    wr_en = 1'b0; rsv_en = 1'b0; clr_req = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Counts busy cycles (bounded); optional junk writes/reserves while busy.
  task automatic count_busy(input bit noise, output int n);
    bit done;
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (noise) begin
        wr_en = 1'b1; wr_sel = AW'($urandom); wr_data = $urandom;
        rsv_en = 1'b1; rsv_sel = AW'($urandom);
      end
      @(negedge clk);
      model_check();
      if (clr_busy === 1'b1) n++;
      else begin
        done = 1'b1;
        idle();
      end
      @(posedge clk);
      model_update();
      #1;
    end
  endtask

  task automatic wait_idle();
    idle();
    for (int i = 0; i < 100 && m_left > 0; i++) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 32'hDEADBEEF, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 5'd0, 32'h0,        1'b0, 32'h0};
    tbl[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 32'h0,        1'b0, 32'h0};
    tbl[4]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd7, 32'h0,        1'b0, 32'h0};
    tbl[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 32'h0,        1'b1, 32'h0};
    tbl[6]  = '{1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd7, 32'hA5A5A5A5, 1'b1, 32'h0};
    tbl[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5};
    tbl[8]  = '{1'b1, 5'd7, 32'h11111111, 1'b1, 5'd7, 5'd7, 32'h11111111, 1'b0, 32'hA5A5A5A5};
    tbl[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 32'h11111111, 1'b1, 32'h11111111};
    tbl[10] = '{1'b1, 5'd7, 32'h22222222, 1'b0, 5'd0, 5'd7, 32'h22222222, 1'b1, 32'h11111111};
    tbl[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 32'h22222222, 1'b0, 32'h22222222};

    // Reset, then the post-reset clear must take exactly DEPTH cycles.
    rst_n = 1'b0; rd_sel = '0; wr_sel = '0; wr_data = '0; rsv_sel = '0;
    idle();
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    count_busy(1'b0, n);
    chk("reset_clear_len", 32'(n), 32'(DEPTH));

    // Directed table: bypass, zero register, scoreboard priority.
    for (int t = 0; t < 12; t++) begin
      wr_en = tbl[t].we; wr_sel = tbl[t].ws; wr_data = tbl[t].wd;
      rsv_en = tbl[t].re; rsv_sel = tbl[t].rs; clr_req = 1'b0;
      rd_sel = NR*AW'($urandom);
      rd_sel[AW-1:0] = tbl[t].sel;
      @(negedge clk);
      model_check();
      chk($sformatf("tbl%0d_data", t), rd_data[XLEN-1:0], tbl[t].ed);
      chk($sformatf("tbl%0d_pend", t), 32'(rd_pend[0]), 32'(tbl[t].ep));
      chk($sformatf("tbl%0d_nb", t), nb_data, tbl[t].enb);
      @(posedge clk);
      model_update();
      #1;
    end
    idle();

    // Random traffic with occasional clear requests.
    for (int i = 0; i < 600; i++) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_sel  = AW'($urandom);
      wr_data = $urandom;
      rsv_en  = ($urandom_range(0, 2) == 0);
      rsv_sel = ($urandom_range(0, 3) == 0) ? wr_sel : AW'($urandom);
      clr_req = ($urandom_range(0, 99) == 0);
      for (int k = 0; k < NR; k++)
        rd_sel[k*AW +: AW] = ($urandom_range(0, 3) == 0) ? wr_sel : AW'($urandom);
      tick();
    end

    // Fill, reserve, request a clear; writes during it must be dropped.
    wait_idle();
    for (int r = 1; r < DEPTH; r++) begin
      wr_en = 1'b1; wr_sel = AW'(r); wr_data = 32'(r);
      rsv_en = 1'b0;
      tick();
    end
    wr_en = 1'b0; rsv_en = 1'b1; rsv_sel = 5'd3; tick();
    rsv_sel = 5'd9; tick();
    rsv_en = 1'b0; rd_sel = {5'd9, 5'd3, 5'd2, 5'd1};
    @(negedge clk);
    chk("prefill_pend", 32'(rd_pend), 32'b1100);
    chk("prefill_r2", rd_data[XLEN +: XLEN], 32'd2);
    @(posedge clk);
    model_update();
    #1;
    clr_req = 1'b1; tick();
    clr_req = 1'b0;
    count_busy(1'b1, n);
    chk("req_clear_len", 32'(n), 32'(DEPTH));
    for (int g = 0; g < DEPTH / NR; g++) begin
      for (int k = 0; k < NR; k++) rd_sel[k*AW +: AW] = AW'(g*NR + k);
      @(negedge clk);
      model_check();
      chk($sformatf("cleared_grp%0d", g), rd_data[31:0] | rd_data[63:32] | rd_data[95:64] | rd_data[127:96], 32'h0);
      chk($sformatf("cleared_pend%0d", g), 32'(rd_pend), 32'h0);
      @(posedge clk);
      model_update();
      #1;
    end

    // Reset asserted mid-clear (clr_idx=10) restarts the full sequence.
    clr_req = 1'b1; tick();
    clr_req = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midclr_rst_busy", 32'(clr_busy), 32'h1);
    #1;
    rst_n = 1'b1;
    count_busy(1'b0, n);
    chk("restart_clear_len", 32'(n), 32'(DEPTH));

    for (int r = 0; r < NR; r++) begin
      wr_en = 1'b1; wr_sel = AW'(10 + r); wr_data = 32'hC0DE0000 + 32'(r);
      tick();
    end
    idle();
    rd_sel = {5'd13, 5'd12, 5'd11, 5'd10};
    @(negedge clk);
    model_check();
    for (int k = 0; k < NR; k++)
      chk($sformatf("distinct_port%0d", k), rd_data[k*XLEN +: XLEN], 32'hC0DE0000 + 32'(k));
    @(posedge clk);
    model_update();
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-read-port integer register file, successor to the single-write, dual-read CPU register file.
- Configurable data width, depth and read-port count.
- Optional hardwired-zero entry 0.
- Optional write-to-read bypass.
- Per-register pending scoreboard for pipeline hazard detection.
- Sequential clear engine that zeroes the array after reset or on request.
Sits between decode (read/reserve) and writeback (write) in the pipelined core.

Parameters:
XLEN, 32, data width in bits
DEPTH, 32, number of registers (power of two, >= 2)
AW, $clog2(DEPTH), index width (derived, not overridden)
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = entry 0 reads 0, ignores writes, never pending
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports

Ports:
clk  in  1  clock, all state updates on posedge
rst_n  in  1  asynchronous active-low reset
rd_sel  in  NUM_RD*AW  read indices, port k at [k*AW +: AW]
rd_data  out  NUM_RD*XLEN  read data, port k at [k*XLEN +: XLEN]
rd_pend  out  NUM_RD  pending flag of the register addressed by each read port
wr_en  in  1  write enable
wr_sel  in  AW  write index
wr_data  in  XLEN  write data
rsv_en  in  1  mark register pending (decode issued a producer)
rsv_sel  in  AW  index to reserve
clr_req  in  1  request full-array clear (pulse or level)
clr_busy  out  1  clear engine active; writes and reserves ignored

Behaviour:
- Reset (async assert, rst_n=0):
  - FSM=CLEAR, clr_idx=0, all pending bits 0, clr_busy=1.
  - Array contents are not reset directly; the clear engine zeroes them.
- FSM states:
  - CLEAR: writes 0 to entry clr_idx each cycle, then clr_idx++. In the cycle where clr_idx==DEPTH-1, the next state is IDLE.
    - From reset deassert, clearing takes exactly DEPTH cycles; clr_busy falls on the edge that completes entry DEPTH-1.
  - IDLE: clr_busy=0. clr_req=1 sampled at a posedge gives CLEAR next cycle with clr_idx=0 and all pending bits cleared on that edge.
- clr_req while in CLEAR is ignored; it does not extend or restart the sequence.
- Reset asserted mid-clear restarts the sequence at clr_idx=0.
- While clr_busy=1:
  - rd_data=0 and rd_pend=0 on all ports.
  - wr_en and rsv_en have no effect.
- Reads are combinational, zero latency: rd_data[k] = regs[rd_sel[k]].
  - ZERO_REG=1 and rd_sel[k]==0: rd_data[k]=0 regardless of array contents.
- Writes are synchronous: on posedge, if wr_en && !clr_busy && !(ZERO_REG && wr_sel==0), then regs[wr_sel] <= wr_data.
- Bypass (BYPASS=1): if wr_en && !clr_busy && wr_sel==rd_sel[k] and wr_sel is a writable index, then rd_data[k]=wr_data in the same cycle. With BYPASS=0, the old value is returned until the next edge.
- Scoreboard (pend[DEPTH-1:0]) updates on posedge:
  - Valid write to index i clears pend[i].
  - rsv_en sets pend[rsv_sel].
  - Simultaneous write and reserve to the same index: set wins (the new producer supersedes the old one).
  - ZERO_REG=1: pend[0] is constant 0.
- rd_pend[k] = pend[rd_sel[k]], combinational. Not bypassed: a write in the current cycle still shows pending until the edge.
- All NUM_RD ports are independent. Any number of ports may address the same index.

Decomposition:
- Package regfile_pkg:
  - rf_state_e enum {RF_CLEAR, RF_IDLE}.
  - Default constants RF_XLEN=32 and RF_DEPTH=32.
  - Width helper function for AW.
- Sub-module rf_scoreboard holds the pending-bit vector with set/clear priority and the read-port mux for rd_pend; parameters DEPTH, NUM_RD, ZERO_REG.
- The clear FSM and the array stay in regfile_mp.

Test Plan:
1. Reset release, hold idle inputs → clr_busy=1 for exactly 32 cycles, then 0; every read returns 0x00000000.
2. After clear, write 0xDEADBEEF to r5 → same-cycle rd_data[0]=0xDEADBEEF with rd_sel[0]=5 (BYPASS=1); next cycle r5 still reads 0xDEADBEEF. With BYPASS=0, the same-cycle read returns 0.
3. Write 0x12345678 to r0 → r0 reads 0 on every port, rd_pend for r0 stays 0 after rsv_en with rsv_sel=0.
4. rsv_en r7 → rd_pend=1 next cycle; write r7 → pend clears after the edge. Same-cycle write r7 with rsv_en r7 → pend stays 1.
5. Fill r1..r31 with the index value, pulse clr_req → clr_busy high 32 cycles, writes during clear are dropped, every register reads 0 afterwards, all pending bits are 0.
6. Assert rst_n=0 at clr_idx=10 during a clear → after release, clear restarts and lasts the full 32 cycles; with NUM_RD=4, all ports reading distinct registers return correct values.
